// File: rtl/rbcp_pkg.sv
// Shared types and widths for RBCP slave register banks.
package rbcp_pkg;

    localparam int unsigned RBCP_ADDR_W = 32;
    localparam int unsigned RBCP_DATA_W = 8;
    localparam int unsigned RBCP_IDX_W  = 6;
    localparam int unsigned RBCP_LAT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } rbcp_state_e;

    typedef enum logic [1:0] {
        KIND_CTRL,
        KIND_STAT,
        KIND_PULSE,
        KIND_NONE
    } rbcp_kind_e;

    typedef struct packed {
        logic                  in_win;
        rbcp_kind_e            kind;
        logic [RBCP_IDX_W-1:0] idx;
    } rbcp_dec_t;

endpackage

// File: rtl/rbcp_addr_decode.sv
// Maps an RBCP byte address onto a bank's control/status/pulse window.
module rbcp_addr_decode
    import rbcp_pkg::*;
#(
    parameter logic [RBCP_ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned            N_CTRL    = 16,
    parameter int unsigned            N_STAT    = 16
) (
    input  logic [RBCP_ADDR_W-1:0] addr,
    output rbcp_dec_t              dec_c
);

    localparam logic [RBCP_ADDR_W-1:0] STAT_OFF  = RBCP_ADDR_W'(N_CTRL);
    localparam logic [RBCP_ADDR_W-1:0] PULSE_OFF = RBCP_ADDR_W'(N_CTRL + N_STAT);

    logic [RBCP_ADDR_W-1:0] offset_c;

    // Unsigned subtraction: addresses below the base wrap to huge offsets.
    always_comb begin
        offset_c     = addr - BASE_ADDR;
        dec_c.kind   = KIND_NONE;
        dec_c.idx    = '0;
        if (offset_c < STAT_OFF) begin
            dec_c.kind = KIND_CTRL;
            dec_c.idx  = RBCP_IDX_W'(offset_c);
        end else if (offset_c < PULSE_OFF) begin
            dec_c.kind = KIND_STAT;
            dec_c.idx  = RBCP_IDX_W'(offset_c - STAT_OFF);
        end else if (offset_c == PULSE_OFF) begin
            dec_c.kind = KIND_PULSE;
        end
        dec_c.in_win = (dec_c.kind != KIND_NONE);
    end

endmodule

// File: rtl/rbcp_reg_bank.sv
// RBCP slave register bank: RW control bytes, snapshotted RO status bytes,
// and a write-1 pulse byte, with programmable ack latency.
module rbcp_reg_bank
    import rbcp_pkg::*;
#(
    parameter logic [RBCP_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned            N_CTRL    = 16,
    parameter int unsigned            N_STAT    = 16,
    parameter int unsigned            ACK_LAT   = 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          rbcp_act,
    input  logic [RBCP_ADDR_W-1:0]        rbcp_addr,
    input  logic                          rbcp_we,
    input  logic                          rbcp_re,
    input  logic [RBCP_DATA_W-1:0]        rbcp_wd,
    output logic                          rbcp_ack,
    output logic [RBCP_DATA_W-1:0]        rbcp_rd,
    output logic [RBCP_DATA_W*N_CTRL-1:0] ctrl_out,
    input  logic [RBCP_DATA_W*N_STAT-1:0] stat_in,
    output logic [RBCP_DATA_W-1:0]        pulse_out
);

    localparam int unsigned DW = RBCP_DATA_W;

    rbcp_dec_t dec_c;

    rbcp_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .N_CTRL    (N_CTRL),
        .N_STAT    (N_STAT)
    ) u_dec (
        .addr  (rbcp_addr),
        .dec_c (dec_c)
    );

    rbcp_state_e            state_q, state_d;
    logic [RBCP_LAT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   ack_q, ack_d;
    logic [DW-1:0]          rd_q, rd_d;
    logic [DW*N_CTRL-1:0]   ctrl_q, ctrl_d;
    logic [DW*N_STAT-1:0]   snap_q, snap_d;
    logic [DW-1:0]          pulse_q, pulse_d;
    logic [DW-1:0]          ctrl_rd_c, snap_rd_c;
    logic                   accept_c;

    // Byte read muxes for the addressed control and snapshot bytes.
    always_comb begin
        ctrl_rd_c = '0;
        snap_rd_c = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            if (dec_c.idx == RBCP_IDX_W'(k)) ctrl_rd_c = ctrl_q[k*DW +: DW];
        end
        for (int k = 0; k < N_STAT; k++) begin
            if (dec_c.idx == RBCP_IDX_W'(k)) snap_rd_c = snap_q[k*DW +: DW];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        ack_d    = 1'b0;
        rd_d     = '0;
        ctrl_d   = ctrl_q;
        snap_d   = snap_q;
        pulse_d  = '0;
        accept_c = rbcp_act && (rbcp_we || rbcp_re) && dec_c.in_win;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_WAIT;
                    cnt_d   = RBCP_LAT_W'(ACK_LAT - 1);
                    data_d  = '0;
                    // A write wins over a simultaneous read and returns no data.
                    if (rbcp_we) begin
                        if (dec_c.kind == KIND_CTRL) begin
                            for (int k = 0; k < N_CTRL; k++) begin
                                if (dec_c.idx == RBCP_IDX_W'(k)) ctrl_d[k*DW +: DW] = rbcp_wd;
                            end
                        end else if (dec_c.kind == KIND_PULSE) begin
                            pulse_d = rbcp_wd;
                        end
                    end else if (dec_c.kind == KIND_CTRL) begin
                        data_d = ctrl_rd_c;
                    end else if (dec_c.kind == KIND_STAT) begin
                        // First status byte refreshes the whole snapshot for coherent multi-byte reads.
                        if (dec_c.idx == '0) begin
                            snap_d = stat_in;
                            data_d = stat_in[DW-1:0];
                        end else begin
                            data_d = snap_rd_c;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!rbcp_act) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    rd_d    = data_q;
                end else begin
                    cnt_d = cnt_q - RBCP_LAT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            snap_q  <= '0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            snap_q  <= snap_d;
            pulse_q <= pulse_d;
        end
    end

    assign rbcp_ack  = ack_q;
    assign rbcp_rd   = rd_q;
    assign ctrl_out  = ctrl_q;
    assign pulse_out = pulse_q;

endmodule

// File: doc/rbcp_reg_bank.md
# rbcp_reg_bank

Parametrised RBCP slave register bank on the `sys_clk` domain, attached to the SiTCP RBCP port (`RBCP_ACT/ADDR/WE/RE/WD` in, `RBCP_ACK/RD` out). It replaces hard-tied RBCP ack/data with byte-addressed control (RW), status (RO, coherent snapshot) and pulse (write-1 strobe) registers. It occupies a configurable address window. Acks and read data are zero outside its window, so several banks can share one RBCP bus by OR-ing `rbcp_ack` and `rbcp_rd`.

## Interface
- `BASE_ADDR`, 32'h0000_0000: first byte address of the window.
- `N_CTRL`, 16: number of 8-bit RW control bytes (1..64).
- `N_STAT`, 16: number of 8-bit RO status bytes (1..64).
- `ACK_LAT`, 1: cycles from accepted strobe to `rbcp_ack` (1..15).
- `sys_clk`  in  1  sole clock (SiTCP `CLK`).
- `sys_rst_n`  in  1  reset; synchronous, active-low.
- `rbcp_act`  in  1  RBCP transaction active.
- `rbcp_addr`  in  32  byte address.
- `rbcp_we`  in  1  write strobe, 1 cycle.
- `rbcp_re`  in  1  read strobe, 1 cycle.
- `rbcp_wd`  in  8  write data.
- `rbcp_ack`  out  1  access acknowledge, 1-cycle pulse.
- `rbcp_rd`  out  8  read data, valid only with `rbcp_ack`, else 0.
- `ctrl_out`  out  8*N_CTRL  control bytes; byte k = bits [8k+7:8k].
- `stat_in`  in  8*N_STAT  status vector from user logic (same clock).
- `pulse_out`  out  8  one-cycle strobes.

## Operation
- Address map, with offset = `rbcp_addr` − `BASE_ADDR` (unsigned 32-bit):
  - control: 0..N_CTRL−1
  - status: N_CTRL..N_CTRL+N_STAT−1
  - pulse: N_CTRL+N_STAT
  - Anything else, including negative offset (wrap), is out of window.
- A strobe is accepted only in IDLE with `rbcp_act`=1 and in-window offset. Out-of-window strobes are ignored: no ack, no side effect.
- Simultaneous `rbcp_we` and `rbcp_re`: treated as a write; no read data.
- Write to control byte: byte updated the cycle after the strobe.
- Write to status byte: no effect, still acked.
- Write to pulse byte: `pulse_out` = `rbcp_wd` for exactly 1 cycle, starting the cycle after the strobe, then 0.
- Read of control byte: returns current value.
- Read of pulse byte: returns 0.
- Status snapshot: a read of status offset N_CTRL (first status byte) latches the whole `stat_in` into a snapshot register the same cycle. All status reads return snapshot bytes, so multi-byte counters read low-to-high are coherent.
- FSM:
  - IDLE: on accepted strobe → WAIT; load latency counter with ACK_LAT−1; latch offset, kind and read data.
  - WAIT: while counter≠0 decrement; at 0 → ACK.
  - ACK: `rbcp_ack`=1 and `rbcp_rd`=latched data for one cycle → IDLE.
  - With ACK_LAT=1, WAIT lasts 1 cycle.
- `rbcp_act` falling in WAIT: abort → IDLE, no ack. A write's register side effect has already occurred and is not reverted.
- Strobes arriving outside IDLE are ignored.

## Timing
- Strobe at cycle T → `rbcp_ack` high at T+ACK_LAT+1, for exactly 1 cycle.
- Read data is sampled at T, not at ack.
- All outputs are registered.
- Reset (`sys_rst_n`=0 at a clock edge): FSM → IDLE; `ctrl_out`, snapshot, `pulse_out`, `rbcp_ack`, `rbcp_rd` all 0 the next cycle. Reset mid-transaction drops the pending ack.
- Back-to-back strobes: the next transaction may be accepted in the IDLE cycle right after ACK.
- Throughput: 1 access per ACK_LAT+2 cycles.

## Structure
- Shared package `rbcp_pkg`:
  - FSM state enum (IDLE/WAIT/ACK)
  - access-kind enum (CTRL/STAT/PULSE/NONE)
  - `RBCP_ADDR_W`=32, `RBCP_DATA_W`=8
- One sub-module `rbcp_addr_decode`: combinational offset compute, window check, kind and index output. Reused by later banks.
- Instantiated by the top level next to SiTCP; acks from multiple banks are OR-combined there.

## Test plan
- Write 8'hA5 at BASE_ADDR+3 (defaults) → `ctrl_out`[31:24]=8'hA5 the next cycle; ack at T+2; read of same address returns 8'hA5.
- `stat_in` low byte 8'h10, then read offset 16 at T. At T+1 change `stat_in` to all 8'hFF, then read offset 17 → returns the snapshot byte taken at T, not 8'hFF.
- Write 8'h81 to offset 32 → `pulse_out`=8'h81 for exactly 1 cycle, then 8'h00; read offset 32 → 0.
- Read at BASE_ADDR+33, and at BASE_ADDR−1 with BASE_ADDR=32'h100 → no ack within 20 cycles; `rbcp_rd` stays 0.
- ACK_LAT=4: drop `rbcp_act` at T+2 → no ack. Separately, assert reset at T+2 → no ack and all outputs 0.
- Simultaneous we+re at offset 0 with wd 8'h3C → ctrl byte 0 = 8'h3C; the single ack carries `rbcp_rd`=0.
